// File: rtl/cv32e40p_pkg.sv
// Shared type definitions for the cv32e40p slice.
// Currently only holds the bitmask sequencer state encoding.
package cv32e40p_pkg;

    // Bitmask sequencer control states
    typedef enum logic {
        BMS_IDLE = 1'b0,
        BMS_SCAN = 1'b1
    } bitmask_seq_state_e;

endpackage : cv32e40p_pkg

// File: rtl/cv32e40p_ff_one.sv
// Find-first-one tree.
// Reports the index of the lowest set bit of in_i, plus a flag when no bit is set.
// The input is padded up to a power of two.
// Each tree level then merges pairs of nodes, and the lower-indexed child wins when both are set.
module cv32e40p_ff_one #(
    parameter int LEN = 32
) (
    input  logic [LEN-1:0]          in_i,
    output logic [$clog2(LEN)-1:0]  first_one_o,
    output logic                    no_ones_o
);

    localparam int LEVELS = $clog2(LEN);
    localparam int LEAVES = 1 << LEVELS;

    logic              nodeValid [LEVELS+1][LEAVES];
    logic [LEVELS-1:0] nodeIdx   [LEVELS+1][LEAVES];

    // Build the reduction tree level by level, preferring the lower half at every merge
    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            for (int n = 0; n < LEAVES; n++) begin
                nodeValid[l][n] = 1'b0;
                nodeIdx[l][n]   = '0;
            end
        end
        for (int n = 0; n < LEN; n++) begin
            nodeValid[0][n] = in_i[n];
            nodeIdx[0][n]   = LEVELS'(n);
        end
        for (int l = 1; l <= LEVELS; l++) begin
            for (int n = 0; n < (LEAVES >> l); n++) begin
                nodeValid[l][n] = nodeValid[l-1][2*n] | nodeValid[l-1][2*n+1];
                nodeIdx[l][n]   = nodeValid[l-1][2*n] ? nodeIdx[l-1][2*n] : nodeIdx[l-1][2*n+1];
            end
        end
    end

    assign first_one_o = nodeIdx[LEVELS][0];
    assign no_ones_o   = !nodeValid[LEVELS][0];

endmodule : cv32e40p_ff_one

// File: rtl/cv32e40p_bitmask_sequencer.sv
// Bitmask sequencer.
// Latches a mask and hands out the index of every set bit, lowest first.
// One index is handed out per valid/ready handshake.
// A residual copy of the mask feeds the find-first-one tree.
// Each consumed bit is cleared from the residual, so the tree always points at the next index.
module cv32e40p_bitmask_sequencer
    import cv32e40p_pkg::*;
#(
    parameter int LEN   = 32,
    parameter int IDX_W = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic [LEN-1:0]   mask_i,
    input  logic             mask_valid_i,
    output logic             mask_ready_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             idx_valid_o,
    input  logic             idx_ready_i,
    output logic             idx_last_o,
    output logic [IDX_W:0]   cnt_o,
    output logic             done_o,
    output logic             busy_o
);

    bitmask_seq_state_e state_q, state_d;
    logic [LEN-1:0]     residual_q, residual_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   firstOne;
    logic               residualEmpty;
    logic               handshake;

    cv32e40p_ff_one #(
        .LEN (LEN)
    ) ffOne (
        .in_i        (residual_q),
        .first_one_o (firstOne),
        .no_ones_o   (residualEmpty)
    );

    // Outputs are decoded purely from registers so no input reaches an output combinationally
    always_comb begin
        mask_ready_o = (state_q == BMS_IDLE);
        idx_valid_o  = (state_q == BMS_SCAN);
        busy_o       = (state_q == BMS_SCAN);
        idx_o        = firstOne;
        idx_last_o   = idx_valid_o && ((residual_q & (residual_q - LEN'(1))) == '0);
        cnt_o        = cnt_q;
        done_o       = done_q;
    end

    assign handshake = idx_valid_o && idx_ready_i;

    // Next-state logic: flush overrides everything; an empty mask finishes without scanning
    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;

        if (flush_i) begin
            state_d    = BMS_IDLE;
            residual_d = '0;
        end else begin
            case (state_q)
                BMS_IDLE: begin
                    if (mask_valid_i) begin
                        residual_d = mask_i;
                        cnt_d      = '0;
                        if (mask_i != '0) begin
                            state_d = BMS_SCAN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                BMS_SCAN: begin
                    if (handshake) begin
                        residual_d = residual_q & ~(LEN'(1) << firstOne);
                        cnt_d      = cnt_q + (IDX_W+1)'(1);
                        if (idx_last_o) begin
                            state_d = BMS_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = BMS_IDLE;
                    residual_d = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BMS_IDLE;
            residual_q <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    // A presented index must stay put until the consumer takes it (flush may withdraw it)
    assert property (@(posedge clk) disable iff (!rst_n)
        (idx_valid_o && !idx_ready_i && !flush_i) |=> (idx_valid_o && $stable(idx_o)));

    // Scanning only ever happens with at least one bit left to emit
    assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == BMS_SCAN) |-> !residualEmpty);

endmodule : cv32e40p_bitmask_sequencer

// File: tb/tb_cv32e40p_bitmask_sequencer.sv
// Directed testbench for the bitmask sequencer.
// A 32-bit instance covers the main sequencing cases.
// A 5-bit instance covers asynchronous reset taken in the middle of a scan.
module tb_cv32e40p_bitmask_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] mask;
    logic        maskValid;
    logic        maskReady;
    logic [4:0]  idx;
    logic        idxValid;
    logic        idxReady;
    logic        idxLast;
    logic [5:0]  cnt;
    logic        done;
    logic        busy;

    logic        sRstN;
    logic        sFlush;
    logic [4:0]  sMask;
    logic        sMaskValid;
    logic        sMaskReady;
    logic [2:0]  sIdx;
    logic        sIdxValid;
    logic        sIdxReady;
    logic        sIdxLast;
    logic [3:0]  sCnt;
    logic        sDone;
    logic        sBusy;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    cv32e40p_bitmask_sequencer #(.LEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .mask_i       (mask),
        .mask_valid_i (maskValid),
        .mask_ready_o (maskReady),
        .idx_o        (idx),
        .idx_valid_o  (idxValid),
        .idx_ready_i  (idxReady),
        .idx_last_o   (idxLast),
        .cnt_o        (cnt),
        .done_o       (done),
        .busy_o       (busy)
    );

    cv32e40p_bitmask_sequencer #(.LEN(5)) dutSmall (
        .clk          (clk),
        .rst_n        (sRstN),
        .flush_i      (sFlush),
        .mask_i       (sMask),
        .mask_valid_i (sMaskValid),
        .mask_ready_o (sMaskReady),
        .idx_o        (sIdx),
        .idx_valid_o  (sIdxValid),
        .idx_ready_i  (sIdxReady),
        .idx_last_o   (sIdxLast),
        .cnt_o        (sCnt),
        .done_o       (sDone),
        .busy_o       (sBusy)
    );

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the inputs of the 32-bit instance
    task automatic applyStimulus(input logic [31:0] m, input logic mv, input logic rdy, input logic fl);
        mask      = m;
        maskValid = mv;
        idxReady  = rdy;
        flush     = fl;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Check the idle-side outputs of the 32-bit instance in one call
    task automatic checkIdle(input string tag, input logic [31:0] expDone, input logic [31:0] expCnt);
        checkOutput({tag, " maskReady"}, 32'(maskReady), 1);
        checkOutput({tag, " idxValid"}, 32'(idxValid), 0);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " done"}, 32'(done), expDone);
        checkOutput({tag, " cnt"}, 32'(cnt), expCnt);
    endtask

    // Check a presented index on the 32-bit instance
    task automatic checkIdx(input string tag, input logic [31:0] expIdx, input logic [31:0] expLast);
        checkOutput({tag, " idxValid"}, 32'(idxValid), 1);
        checkOutput({tag, " idx"}, 32'(idx), expIdx);
        checkOutput({tag, " idxLast"}, 32'(idxLast), expLast);
        checkOutput({tag, " maskReady"}, 32'(maskReady), 0);
        checkOutput({tag, " done"}, 32'(done), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        sRstN = 1'b0;
        sFlush = 1'b0;
        sMask = '0;
        sMaskValid = 1'b0;
        sIdxReady = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkIdle("reset", 0, 0);
        rst_n = 1'b1;
        sRstN = 1'b1;
        tick();
        checkIdle("postReset", 0, 0);

        $display("[TB] empty mask");
        applyStimulus(32'h0000_0000, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        checkIdle("empty pulse", 1, 0);
        tick();
        checkIdle("empty after", 0, 0);

        $display("[TB] mask 8000_0011 always ready");
        applyStimulus(32'h8000_0011, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        checkIdx("m11 first", 0, 0);
        checkOutput("m11 busy", 32'(busy), 1);
        tick();
        checkIdx("m11 second", 4, 0);
        checkOutput("m11 cnt1", 32'(cnt), 1);
        tick();
        checkIdx("m11 third", 31, 1);
        checkOutput("m11 cnt2", 32'(cnt), 2);
        tick();
        checkIdle("m11 done", 1, 3);
        tick();
        checkIdle("m11 after", 0, 3);

        $display("[TB] mask 0000_0006 with stall");
        applyStimulus(32'h0000_0006, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkIdx($sformatf("m6 stall %0d", i), 1, 0);
            checkOutput($sformatf("m6 stall cnt %0d", i), 32'(cnt), 0);
            tick();
        end
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        checkIdx("m6 release", 1, 0);
        tick();
        checkIdx("m6 last", 2, 1);
        tick();
        checkIdle("m6 done", 1, 2);

        $display("[TB] mask FFFF_FFFF always ready");
        applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            checkIdx($sformatf("ones %0d", i), 32'(i), (i == 31) ? 1 : 0);
            tick();
        end
        checkIdle("ones done", 1, 32);
        tick();
        checkIdle("ones after", 0, 32);

        $display("[TB] mask 0000_00F0 with flush");
        applyStimulus(32'h0000_00F0, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        checkIdx("f0 first", 4, 0);
        tick();
        checkIdx("f0 second", 5, 0);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        checkIdle("f0 flushed", 0, 1);
        checkOutput("f0 residual", dut.residual_q, 0);
        tick();
        checkIdle("f0 settled", 0, 1);

        $display("[TB] flush beats mask accept");
        applyStimulus(32'h0000_0003, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        checkIdle("flushAccept", 0, 1);
        tick();
        checkIdle("flushAccept after", 0, 1);

        $display("[TB] mask 0000_0001 after flush");
        applyStimulus(32'h0000_0001, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        checkIdx("m1 only", 0, 1);
        checkOutput("m1 cnt", 32'(cnt), 0);
        tick();
        checkIdle("m1 done", 1, 1);

        $display("[TB] LEN=5 reset mid-scan");
        sMask = 5'b10100;
        sMaskValid = 1'b1;
        sIdxReady = 1'b0;
        tick();
        sMaskValid = 1'b0;
        sMask = '0;
        checkOutput("small idxValid", 32'(sIdxValid), 1);
        checkOutput("small idx", 32'(sIdx), 2);
        checkOutput("small idxLast", 32'(sIdxLast), 0);
        #2;
        sRstN = 1'b0;
        #1;
        checkOutput("small rst idxValid", 32'(sIdxValid), 0);
        checkOutput("small rst maskReady", 32'(sMaskReady), 1);
        checkOutput("small rst busy", 32'(sBusy), 0);
        checkOutput("small rst done", 32'(sDone), 0);
        checkOutput("small rst cnt", 32'(sCnt), 0);
        tick();
        sRstN = 1'b1;
        sIdxReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("small post idxValid %0d", i), 32'(sIdxValid), 0);
            checkOutput($sformatf("small post maskReady %0d", i), 32'(sMaskReady), 1);
            checkOutput($sformatf("small post done %0d", i), 32'(sDone), 0);
        end
        sMask = 5'b10001;
        sMaskValid = 1'b1;
        tick();
        sMaskValid = 1'b0;
        checkOutput("small run idx0", 32'(sIdx), 0);
        checkOutput("small run last0", 32'(sIdxLast), 0);
        tick();
        checkOutput("small run idx4", 32'(sIdx), 4);
        checkOutput("small run last4", 32'(sIdxLast), 1);
        tick();
        checkOutput("small run done", 32'(sDone), 1);
        checkOutput("small run cnt", 32'(sCnt), 2);
        checkOutput("small run idxValid", 32'(sIdxValid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_cv32e40p_bitmask_sequencer
